// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte-level write sink and read source with open-drain SDA control.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       op,
    output logic       busy,
    output logic       wr_valid,
    output logic [7:0] wr_byte,
    output logic       rd_req,
    input  logic [7:0] rd_byte,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [1:0] {ST_INIT, ST_ADDR, ST_IN, ST_OUT} state_e;

    state_e      state_q;
    logic        scl_s1_q, scl_s2_q, scl_h_q;
    logic        sda_s1_q, sda_s2_q, sda_h_q;
    logic [3:0]  bit_cnt_q;
    logic [3:0]  bit_cnt_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic        ack_q;
    logic        sda_oe_q, op_q, wr_valid_q, rd_req_q, start_det_q, stop_det_q;
    logic [7:0]  wr_byte_q;

    logic scl_rise, scl_fall, start_ev, stop_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_ev  = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_ev   = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
    assign bit_cnt_d = bit_cnt_q + 4'd1;
    assign shift_d   = {shift_q[6:0], sda_s2_q};

    // ack_q marks the ninth-bit phase: our ACK in ADDR/IN, the master's ACK in OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ack_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            op_q        <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_byte_q   <= '0;
            rd_req_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            wr_valid_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            if (start_ev) begin
                state_q     <= ST_ADDR;
                bit_cnt_q   <= '0;
                ack_q       <= 1'b0;
                sda_oe_q    <= 1'b0;
                start_det_q <= 1'b1;
            end else if (stop_ev) begin
                state_q    <= ST_INIT;
                bit_cnt_q  <= '0;
                ack_q      <= 1'b0;
                sda_oe_q   <= 1'b0;
                stop_det_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_INIT: ;
                    ST_ADDR: begin
                        if (scl_fall && ack_q) begin
                            ack_q     <= 1'b0;
                            bit_cnt_q <= '0;
                            sda_oe_q  <= 1'b0;
                            if (op_q) begin
                                rd_req_q <= 1'b1;
                                state_q  <= ST_OUT;
                            end else begin
                                state_q  <= ST_IN;
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                op_q     <= shift_q[0];
                                sda_oe_q <= 1'b1;
                                ack_q    <= 1'b1;
                            end else begin
                                state_q  <= ST_INIT;
                            end
                        end else if (scl_rise && bit_cnt_q < 4'd8) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_d;
                        end
                    end
                    ST_IN: begin
                        if (scl_fall && ack_q) begin
                            ack_q     <= 1'b0;
                            bit_cnt_q <= '0;
                            sda_oe_q  <= 1'b0;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            wr_byte_q  <= shift_q;
                            wr_valid_q <= 1'b1;
                            sda_oe_q   <= 1'b1;
                            ack_q      <= 1'b1;
                        end else if (scl_rise && bit_cnt_q < 4'd8) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_d;
                        end
                    end
                    ST_OUT: begin
                        // rd_byte is valid the cycle after our request pulse
                        if (rd_req_q) begin
                            shift_q   <= rd_byte;
                            sda_oe_q  <= ~rd_byte[7];
                            bit_cnt_q <= '0;
                        end else if (scl_fall && ack_q) begin
                            ack_q     <= 1'b0;
                            bit_cnt_q <= '0;
                            rd_req_q  <= 1'b1;
                        end else if (scl_fall && bit_cnt_q < 4'd8) begin
                            bit_cnt_q <= bit_cnt_d;
                            shift_q   <= {shift_q[6:0], 1'b0};
                            sda_oe_q  <= (bit_cnt_d == 4'd8) ? 1'b0 : ~shift_q[6];
                        end else if (scl_rise && bit_cnt_q == 4'd8) begin
                            if (sda_s2_q) state_q <= ST_INIT;
                            else          ack_q   <= 1'b1;
                        end
                    end
                    default: state_q <= ST_INIT;
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign op        = op_q;
    assign busy      = (state_q != ST_INIT);
    assign wr_valid  = wr_valid_q;
    assign wr_byte   = wr_byte_q;
    assign rd_req    = rd_req_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master, pulse monitor and a
// transaction-level expectation model (address match, byte lists, pulse counts).
module tb_i2c_slave_responder;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_bus;
    logic       sda_oe, op, busy, wr_valid, rd_req, start_det, stop_det;
    logic [7:0] wr_byte;
    logic [7:0] rd_byte = 8'h00;

    int errors = 0;
    int checks = 0;

    logic [7:0] wr_log[$];
    logic [7:0] rd_data[4];
    int rd_base = 0;
    int rd_req_cnt = 0, start_cnt = 0, stop_cnt = 0, oe_cnt = 0, oe_glitch = 0;
    logic prev_oe = 1'b0;
    bit model_op = 1'b0;

    typedef struct {
        logic [7:0]  addr_byte;
        int unsigned n;
        logic [7:0]  d0, d1, d2;
        bit          exp_ack;
        bit          exp_op;
    } vec_t;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_responder #(.SLAVE_ADDR(7'h22)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_oe(sda_oe), .op(op), .busy(busy), .wr_valid(wr_valid),
        .wr_byte(wr_byte), .rd_req(rd_req), .rd_byte(rd_byte),
        .start_det(start_det), .stop_det(stop_det)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) wr_log.push_back(wr_byte);
        if (rd_req) begin
            rd_byte = (rd_req_cnt - rd_base < 4) ? rd_data[rd_req_cnt - rd_base] : 8'hEE;
            rd_req_cnt++;
        end
        if (start_det) start_cnt++;
        if (stop_det) stop_cnt++;
        if (sda_oe) oe_cnt++;
        if (!rst && sda_oe != prev_oe && scl_m && !start_det && !stop_det) oe_glitch++;
        prev_oe = sda_oe;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit model_ack(input logic [7:0] ab);
        return (ab >> 1) == 8'h22;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_bus;  wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        logic b;
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(b);
        ack = ~b;
    endtask

    task automatic read_byte(input bit ack_it, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(~ack_it);
    endtask

    task automatic run_txn(input logic [7:0] ab, input int unsigned n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input bit exp_ack, input bit exp_op);
        logic [7:0] d[3];
        logic [7:0] got;
        bit a;
        int wr_base, st_base, sp_base, oe_base, exp_wr, exp_rd;
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int i = 0; i < 3; i++) rd_data[i] = d[i];
        rd_data[3] = 8'hEE;
        rd_base = rd_req_cnt;
        wr_base = wr_log.size();
        st_base = start_cnt; sp_base = stop_cnt; oe_base = oe_cnt;
        i2c_start();
        write_byte(ab, a);
        chk("addr_ack", 32'(a), 32'(exp_ack));
        chk("busy_after_addr", 32'(busy), 32'(exp_ack));
        if (!ab[0]) begin
            for (int i = 0; i < int'(n); i++) begin
                write_byte(d[i], a);
                chk("data_ack", 32'(a), 32'(exp_ack));
            end
        end else if (exp_ack) begin
            for (int i = 0; i < int'(n); i++) begin
                read_byte(i != int'(n) - 1, got);
                chk("rd_data", 32'(got), 32'(d[i]));
            end
        end
        i2c_stop();
        wait_clk(6);
        exp_wr = (exp_ack && !ab[0]) ? int'(n) : 0;
        exp_rd = (exp_ack && ab[0]) ? int'(n) : 0;
        chk("wr_count", 32'(wr_log.size() - wr_base), 32'(exp_wr));
        for (int i = 0; i < exp_wr; i++)
            if (wr_base + i < wr_log.size()) chk("wr_byte", 32'(wr_log[wr_base + i]), 32'(d[i]));
        chk("rd_req_count", 32'(rd_req_cnt - rd_base), 32'(exp_rd));
        chk("start_det_count", 32'(start_cnt - st_base), 32'd1);
        chk("stop_det_count", 32'(stop_cnt - sp_base), 32'd1);
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("op", 32'(op), 32'(exp_op));
        chk("sda_oe_idle", 32'(sda_oe), 32'd0);
        if (!exp_ack) chk("sda_oe_never", 32'(oe_cnt - oe_base), 32'd0);
    endtask

    initial begin
        vec_t vecs[3];
        logic [7:0] got;
        bit a;
        int wr_base, st_base, sp_base, rq_base;

        vecs[0] = '{8'h44, 2, 8'hA5, 8'h3C, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h46, 1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'h45, 2, 8'h96, 8'h0F, 8'h00, 1'b1, 1'b1};

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(3);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_byte", 32'(wr_byte), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_start_det", 32'(start_det), 32'd0);
        chk("rst_stop_det", 32'(stop_det), 32'd0);
        rst = 1'b0;
        wait_clk(6);

        // START pulse must appear on the third clock edge after the SDA fall
        @(posedge clk); #1 sda_m = 1'b0;
        @(posedge clk); #1 chk("start_lat_e1", 32'(start_det), 32'd0);
        @(posedge clk); #1 chk("start_lat_e2", 32'(start_det), 32'd0);
        @(posedge clk); #1 chk("start_lat_e3", 32'(start_det), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        @(posedge clk); #1 chk("start_lat_e4", 32'(start_det), 32'd0);
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
        i2c_stop();
        wait_clk(6);
        chk("stop_idle_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 3; v++) begin
            run_txn(vecs[v].addr_byte, vecs[v].n, vecs[v].d0, vecs[v].d1, vecs[v].d2,
                    vecs[v].exp_ack, vecs[v].exp_op);
            model_op = vecs[v].exp_op;
        end

        for (int t = 0; t < 14; t++) begin
            logic [7:0] ab;
            int unsigned r, n;
            bit ack;
            r = $urandom_range(0, 3);
            ab = (r == 0) ? 8'h44 : (r == 1) ? 8'h45 : 8'($urandom);
            n = $urandom_range(1, 3);
            ack = model_ack(ab);
            if (ack) model_op = ab[0];
            run_txn(ab, n, 8'($urandom), 8'($urandom), 8'($urandom), ack, model_op);
        end

        // repeated START: write one byte, then Sr and read one byte with NACK
        wr_base = wr_log.size(); st_base = start_cnt; sp_base = stop_cnt; rq_base = rd_req_cnt;
        rd_data[0] = 8'h5A; rd_data[1] = 8'hEE; rd_base = rd_req_cnt;
        i2c_start();
        write_byte(8'h44, a); chk("sr_addr_w_ack", 32'(a), 32'd1);
        write_byte(8'h11, a); chk("sr_data_ack", 32'(a), 32'd1);
        chk("sr_op_write", 32'(op), 32'd0);
        i2c_start();
        write_byte(8'h45, a); chk("sr_addr_r_ack", 32'(a), 32'd1);
        read_byte(1'b0, got); chk("sr_rd_data", 32'(got), 32'h5A);
        i2c_stop();
        wait_clk(6);
        chk("sr_start_count", 32'(start_cnt - st_base), 32'd2);
        chk("sr_stop_count", 32'(stop_cnt - sp_base), 32'd1);
        chk("sr_op_read", 32'(op), 32'd1);
        chk("sr_wr_count", 32'(wr_log.size() - wr_base), 32'd1);
        if (wr_log.size() > wr_base) chk("sr_wr_byte", 32'(wr_log[wr_base]), 32'h11);
        chk("sr_rd_req_count", 32'(rd_req_cnt - rq_base), 32'd1);
        model_op = 1'b1;

        // STOP after four data bits: partial byte is discarded
        wr_base = wr_log.size(); sp_base = stop_cnt;
        i2c_start();
        write_byte(8'h44, a); chk("pstop_addr_ack", 32'(a), 32'd1);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
        i2c_stop();
        wait_clk(6);
        chk("pstop_wr_count", 32'(wr_log.size() - wr_base), 32'd0);
        chk("pstop_sda_oe", 32'(sda_oe), 32'd0);
        chk("pstop_busy", 32'(busy), 32'd0);
        chk("pstop_stop_count", 32'(stop_cnt - sp_base), 32'd1);
        model_op = 1'b0;

        // asynchronous reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_out(((8'h45 >> i) & 8'h01) != 0);
        chk("rstack_sda_oe_pre", 32'(sda_oe), 32'd1);
        chk("rstack_op_pre", 32'(op), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstack_sda_oe", 32'(sda_oe), 32'd0);
        chk("rstack_op", 32'(op), 32'd0);
        chk("rstack_busy", 32'(busy), 32'd0);
        chk("rstack_wr_valid", 32'(wr_valid), 32'd0);
        chk("rstack_wr_byte", 32'(wr_byte), 32'd0);
        chk("rstack_rd_req", 32'(rd_req), 32'd0);
        chk("rstack_start_det", 32'(start_det), 32'd0);
        chk("rstack_stop_det", 32'(stop_det), 32'd0);
        wait_clk(2);
        rst = 1'b0;
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        run_txn(8'h44, 1, 8'h5C, 8'h00, 8'h00, 1'b1, 1'b0);

        chk("sda_oe_change_while_scl_high", 32'(oe_glitch), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
